// File: rtl/split_merge_tester_if.sv
// Dual-rail token channels between the tester and the split/merge circuit under test.
interface split_merge_tester_if #(
    parameter int unsigned W = 2
);
    logic [2*W-1:0] Tx;
    logic           Txe;
    logic [1:0]     Cx;
    logic           Cxe;
    logic [2*W-1:0] Rx;
    logic           Rxe;

    // Tester side: drives data/control tokens, consumes result tokens.
    modport master (
        output Tx,
        output Cx,
        output Rxe,
        input  Txe,
        input  Cxe,
        input  Rx
    );

    // Circuit-under-test side.
    modport slave (
        input  Tx,
        input  Cx,
        input  Rxe,
        output Txe,
        output Cxe,
        output Rx
    );
endinterface

// File: rtl/split_merge_tester.sv
// Token source and result checker for an asynchronous dual-rail split/merge stage.
// The send side issues NO_TOKENS data+control tokens with four-phase handshakes;
// the receive side captures results, compares them against the expected sequence
// and flags illegal rail codes.
module split_merge_tester #(
    parameter int unsigned W         = 2,
    parameter int unsigned NO_TOKENS = 10,
    parameter int unsigned CTRL_MODE = 0
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 start,
    split_merge_tester_if.master bus,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          tx_count,
    output logic [15:0]          rx_count,
    output logic [W-1:0]         rx_data,
    output logic                 rx_valid,
    output logic                 err_rail,
    output logic                 err_data
);

    localparam int unsigned CW = 16;
    localparam logic [CW-1:0] TOKENS   = CW'(NO_TOKENS);
    // With alternating control only the control=1 half of the tokens returns.
    localparam logic [CW-1:0] RX_TOTAL = (CTRL_MODE == 0) ? CW'(NO_TOKENS)
                                                          : CW'(NO_TOKENS / 2);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_EN,
        DRIVE,
        WAIT_ACK,
        NEUTRAL,
        DONE
    } send_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_WAIT_VALID,
        RX_WAIT_NEUTRAL
    } rx_state_t;

    send_state_t    send_state;
    rx_state_t      rx_state;

    logic           txe_m, txe_s;
    logic           cxe_m, cxe_s;
    logic [2*W-1:0] rx_m, rx_s;

    logic [W-1:0]   rx_one, rx_zero;
    logic           rx_is_valid, rx_is_illegal, rx_is_neutral;
    logic [W-1:0]   rx_expect;

    logic [W-1:0]   tx_word;
    logic [2*W-1:0] tx_enc;
    logic           ctrl_bit;
    logic           start_ok;

    // Two-flop synchronizers for the asynchronous enables and result rails.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            txe_m <= 1'b0;
            txe_s <= 1'b0;
            cxe_m <= 1'b0;
            cxe_s <= 1'b0;
            rx_m  <= '0;
            rx_s  <= '0;
        end else begin
            txe_m <= bus.Txe;
            txe_s <= txe_m;
            cxe_m <= bus.Cxe;
            cxe_s <= cxe_m;
            rx_m  <= bus.Rx;
            rx_s  <= rx_m;
        end
    end

    // Rail (de)interleave: bit i lives on {one = [2i+1], zero = [2i]}.
    for (genvar g = 0; g < W; g++) begin : g_rail
        assign rx_one[g]      = rx_s[2*g+1];
        assign rx_zero[g]     = rx_s[2*g];
        assign tx_enc[2*g+1]  = tx_word[g];
        assign tx_enc[2*g]    = ~tx_word[g];
    end

    assign rx_is_valid   = &(rx_one ^ rx_zero);
    assign rx_is_illegal = |(rx_one & rx_zero);
    assign rx_is_neutral = ~|rx_s;

    assign tx_word   = W'(tx_count);
    assign ctrl_bit  = (CTRL_MODE == 0) ? 1'b1 : tx_count[0];
    // Mode 1 returns the odd-numbered tokens, i.e. 2k+1 for the k-th result.
    assign rx_expect = (CTRL_MODE == 0) ? W'(rx_count) : W'({rx_count, 1'b1});

    // A new run is only accepted when no run is in flight.
    assign start_ok  = start & ~busy;

    // Send FSM: four-phase handshake per token on the data and control channels.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            send_state <= IDLE;
            bus.Tx     <= '0;
            bus.Cx     <= '0;
            tx_count   <= '0;
        end else begin
            case (send_state)
                IDLE, DONE: begin
                    if (start_ok) begin
                        send_state <= WAIT_EN;
                        tx_count   <= '0;
                    end
                end
                WAIT_EN: begin
                    if (txe_s && cxe_s) begin
                        send_state <= DRIVE;
                        bus.Tx     <= tx_enc;
                        bus.Cx     <= ctrl_bit ? 2'b10 : 2'b01;
                    end
                end
                DRIVE: begin
                    send_state <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    // Both channels must acknowledge before the rails are released.
                    if (!txe_s && !cxe_s) begin
                        send_state <= NEUTRAL;
                        bus.Tx     <= '0;
                        bus.Cx     <= '0;
                        if (tx_count != TOKENS) begin
                            tx_count <= tx_count + 16'd1;
                        end
                    end
                end
                NEUTRAL: begin
                    send_state <= (tx_count >= TOKENS) ? DONE : WAIT_EN;
                end
                default: begin
                    send_state <= IDLE;
                end
            endcase
        end
    end

    // Receive FSM: capture each valid result word, check it, wait for neutral.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rx_state <= RX_IDLE;
            bus.Rxe  <= 1'b0;
            rx_count <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            err_rail <= 1'b0;
            err_data <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (start_ok) begin
                rx_state <= RX_WAIT_VALID;
                bus.Rxe  <= 1'b1;
                rx_count <= '0;
                err_rail <= 1'b0;
                err_data <= 1'b0;
            end else begin
                if (rx_is_illegal) begin
                    err_rail <= 1'b1;
                end
                case (rx_state)
                    RX_WAIT_VALID: begin
                        if (rx_is_valid) begin
                            rx_data  <= rx_one;
                            rx_valid <= 1'b1;
                            bus.Rxe  <= 1'b0;
                            rx_state <= RX_WAIT_NEUTRAL;
                            if (rx_count != TOKENS) begin
                                rx_count <= rx_count + 16'd1;
                            end
                            // Surplus results after the expected total are also errors.
                            if ((rx_count >= RX_TOTAL) || (rx_one != rx_expect)) begin
                                err_data <= 1'b1;
                            end
                        end
                    end
                    RX_WAIT_NEUTRAL: begin
                        if (rx_is_neutral) begin
                            rx_state <= RX_WAIT_VALID;
                            bus.Rxe  <= 1'b1;
                        end
                    end
                    default: begin
                        rx_state <= RX_IDLE;
                    end
                endcase
            end
        end
    end

    // Run status: busy from acceptance until both sides finish; done is sticky.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else if (start_ok) begin
            busy <= 1'b1;
            done <= 1'b0;
        end else if (busy && (send_state == DONE) && (rx_count >= RX_TOTAL)) begin
            busy <= 1'b0;
            done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_split_merge_tester.sv
// Directed bench: u0 runs W=2/mode 0/3 tokens, u1 runs W=2/mode 1/4 tokens.
module tb_split_merge_tester;

    typedef struct packed {
        logic [3:0] tx;   // expected Tx rails
        logic [1:0] cx;   // expected Cx rails
        logic       fwd;  // responder returns a result for this token
        logic [3:0] rx;   // result rails the responder drives
        logic [1:0] rxd;  // expected decoded rx_data
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rst;
    logic [1:0] start;
    logic [1:0] txe;
    logic [1:0] cxe;
    logic [3:0] rxd [2];

    wire  [3:0]  tx_w [2];
    wire  [1:0]  cx_w [2];
    wire  [1:0]  rxe;
    wire  [1:0]  busy, done, rx_valid, err_rail, err_data;
    wire  [15:0] tx_cnt [2];
    wire  [15:0] rx_cnt [2];
    wire  [1:0]  rx_data [2];

    vec_t tab [8];
    int   checks = 0;
    int   errors = 0;
    int   vcnt [2] = '{0, 0};
    logic [1:0] vlast [2] = '{2'd0, 2'd0};

    split_merge_tester_if #(.W(2)) if0 ();
    split_merge_tester_if #(.W(2)) if1 ();

    assign if0.Txe = txe[0];
    assign if0.Cxe = cxe[0];
    assign if0.Rx  = rxd[0];
    assign tx_w[0] = if0.Tx;
    assign cx_w[0] = if0.Cx;
    assign rxe[0]  = if0.Rxe;
    assign if1.Txe = txe[1];
    assign if1.Cxe = cxe[1];
    assign if1.Rx  = rxd[1];
    assign tx_w[1] = if1.Tx;
    assign cx_w[1] = if1.Cx;
    assign rxe[1]  = if1.Rxe;

    split_merge_tester #(.W(2), .NO_TOKENS(3), .CTRL_MODE(0)) u0 (
        .CLK(clk), .RESET(rst[0]), .start(start[0]), .bus(if0),
        .busy(busy[0]), .done(done[0]), .tx_count(tx_cnt[0]), .rx_count(rx_cnt[0]),
        .rx_data(rx_data[0]), .rx_valid(rx_valid[0]),
        .err_rail(err_rail[0]), .err_data(err_data[0])
    );

    split_merge_tester #(.W(2), .NO_TOKENS(4), .CTRL_MODE(1)) u1 (
        .CLK(clk), .RESET(rst[1]), .start(start[1]), .bus(if1),
        .busy(busy[1]), .done(done[1]), .tx_count(tx_cnt[1]), .rx_count(rx_cnt[1]),
        .rx_data(rx_data[1]), .rx_valid(rx_valid[1]),
        .err_rail(err_rail[1]), .err_data(err_data[1])
    );

    // Count rx_valid pulses and remember the data captured with each.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rx_valid[k]) begin
                vcnt[k]  <= vcnt[k] + 1;
                vlast[k] <= rx_data[k];
            end
        end
    end

    // Hard stop if the run ever stalls beyond the per-wait budgets.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic cond(input int d, input int kind);
        case (kind)
            0:       return (tx_w[d][3] ^ tx_w[d][2]) & (tx_w[d][1] ^ tx_w[d][0]) & (cx_w[d][1] ^ cx_w[d][0]);
            1:       return (tx_w[d] == 4'b0000) && (cx_w[d] == 2'b00);
            2:       return rxe[d];
            3:       return !rxe[d];
            default: return done[d];
        endcase
    endfunction

    // Poll on falling edges; an expired budget shows up as a failed check.
    task automatic wait_for(input int d, input int kind, input string name);
        int n;
        n = 0;
        while (!cond(d, kind) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(cond(d, kind)), 32'd1);
    endtask

    task automatic pulse_start(input int d);
        start[d] = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_phase(input int d, input int i);
        txe[d] = 1'b1;
        cxe[d] = 1'b1;
        wait_for(d, 0, "tx_valid");
        check("tx_rails", 32'(tx_w[d]), 32'(tab[i].tx));
        check("cx_rails", 32'(cx_w[d]), 32'(tab[i].cx));
        txe[d] = 1'b0;
        cxe[d] = 1'b0;
        wait_for(d, 1, "tx_neutral");
    endtask

    task automatic result_phase(input int d, input int i);
        int n;
        if (tab[i].fwd) begin
            n = vcnt[d];
            wait_for(d, 2, "rxe_high");
            rxd[d] = tab[i].rx;
            wait_for(d, 3, "rxe_low");
            rxd[d] = 4'b0000;
            @(negedge clk);
            check("rx_valid_pulse", 32'(vcnt[d]), 32'(n + 1));
            check("rx_data", 32'(vlast[d]), 32'(tab[i].rxd));
        end
    endtask

    task automatic run_vecs(input int d, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            send_phase(d, i);
            result_phase(d, i);
        end
    endtask

    task automatic fill_mode0();
        tab[0] = '{4'b0101, 2'b10, 1'b1, 4'b0101, 2'd0};
        tab[1] = '{4'b0110, 2'b10, 1'b1, 4'b0110, 2'd1};
        tab[2] = '{4'b1001, 2'b10, 1'b1, 4'b1001, 2'd2};
    endtask

    task automatic fill_mode1();
        tab[0] = '{4'b0101, 2'b01, 1'b0, 4'b0000, 2'd0};
        tab[1] = '{4'b0110, 2'b10, 1'b1, 4'b0110, 2'd1};
        tab[2] = '{4'b1001, 2'b01, 1'b0, 4'b0000, 2'd0};
        tab[3] = '{4'b1010, 2'b10, 1'b1, 4'b1010, 2'd3};
    endtask

    task automatic check_end(input int d, input logic [15:0] ntx, input logic [15:0] nrx,
                             input logic er, input logic ed);
        check("end_done",     32'(done[d]),     32'd1);
        check("end_busy",     32'(busy[d]),     32'd0);
        check("end_tx_count", 32'(tx_cnt[d]),   32'(ntx));
        check("end_rx_count", 32'(rx_cnt[d]),   32'(nrx));
        check("end_err_rail", 32'(err_rail[d]), 32'(er));
        check("end_err_data", 32'(err_data[d]), 32'(ed));
    endtask

    initial begin
        int n;
        rst    = 2'b11;
        start  = 2'b00;
        txe    = 2'b00;
        cxe    = 2'b00;
        rxd[0] = 4'b0000;
        rxd[1] = 4'b0000;
        repeat (3) @(negedge clk);

        // Reset state of both instances.
        for (int d = 0; d < 2; d++) begin
            check("rst_busy",     32'(busy[d]),     32'd0);
            check("rst_done",     32'(done[d]),     32'd0);
            check("rst_tx_count", 32'(tx_cnt[d]),   32'd0);
            check("rst_rx_count", 32'(rx_cnt[d]),   32'd0);
            check("rst_tx",       32'(tx_w[d]),     32'd0);
            check("rst_cx",       32'(cx_w[d]),     32'd0);
            check("rst_rxe",      32'(rxe[d]),      32'd0);
            check("rst_rx_valid", 32'(rx_valid[d]), 32'd0);
            check("rst_err_rail", 32'(err_rail[d]), 32'd0);
            check("rst_err_data", 32'(err_data[d]), 32'd0);
        end
        rst = 2'b00;
        @(negedge clk);

        // Mode 0 loopback, with a start pulse while busy that must be ignored.
        fill_mode0();
        pulse_start(0);
        check("a_busy", 32'(busy[0]), 32'd1);
        run_vecs(0, 0, 0);
        pulse_start(0);
        check("a_ignored_tx", 32'(tx_cnt[0]), 32'd1);
        check("a_ignored_rx", 32'(rx_cnt[0]), 32'd1);
        check("a_still_busy", 32'(busy[0]), 32'd1);
        run_vecs(0, 1, 2);
        wait_for(0, 4, "a_done");
        check_end(0, 16'd3, 16'd3, 1'b0, 1'b0);

        // Surplus result after completion: err_data, rx_count saturated.
        wait_for(0, 2, "x_rxe_high");
        rxd[0] = 4'b1010;
        wait_for(0, 3, "x_rxe_low");
        rxd[0] = 4'b0000;
        @(negedge clk);
        check("x_err_data", 32'(err_data[0]), 32'd1);
        check("x_rx_count", 32'(rx_cnt[0]),   32'd3);
        check("x_done",     32'(done[0]),     32'd1);

        // Restart clears state; Cxe held high while Txe drops keeps rails held.
        pulse_start(0);
        check("b_done_clr",  32'(done[0]),     32'd0);
        check("b_err_clr",   32'(err_data[0]), 32'd0);
        check("b_tx_clr",    32'(tx_cnt[0]),   32'd0);
        check("b_rx_clr",    32'(rx_cnt[0]),   32'd0);
        txe[0] = 1'b1;
        cxe[0] = 1'b1;
        wait_for(0, 0, "b_tx_valid");
        txe[0] = 1'b0;
        repeat (8) @(negedge clk);
        check("b_tx_held",   32'(tx_w[0]),   32'h5);
        check("b_cx_held",   32'(cx_w[0]),   32'h2);
        check("b_tx_nocnt",  32'(tx_cnt[0]), 32'd0);
        cxe[0] = 1'b0;
        wait_for(0, 1, "b_neutral");
        check("b_tx_cnt",    32'(tx_cnt[0]), 32'd1);
        result_phase(0, 0);
        run_vecs(0, 1, 2);
        wait_for(0, 4, "b_done");
        check_end(0, 16'd3, 16'd3, 1'b0, 1'b0);

        // Illegal 11 code on result bit 0: err_rail, no capture.
        pulse_start(0);
        n = vcnt[0];
        rxd[0] = 4'b0011;
        repeat (8) @(negedge clk);
        check("c_err_rail", 32'(err_rail[0]), 32'd1);
        check("c_no_pulse", 32'(vcnt[0]),     32'(n));
        check("c_rx_count", 32'(rx_cnt[0]),   32'd0);
        rxd[0] = 4'b0000;
        repeat (4) @(negedge clk);
        run_vecs(0, 0, 2);
        wait_for(0, 4, "c_done");
        check_end(0, 16'd3, 16'd3, 1'b1, 1'b0);

        // Wrong result (2 instead of 1) on token 1: err_data, run completes.
        pulse_start(0);
        check("d_err_rail_clr", 32'(err_rail[0]), 32'd0);
        tab[1].rx  = 4'b1001;
        tab[1].rxd = 2'd2;
        run_vecs(0, 0, 2);
        wait_for(0, 4, "d_done");
        check_end(0, 16'd3, 16'd3, 1'b0, 1'b1);
        fill_mode0();

        // Reset while in DRIVE: rails neutral next cycle, then a clean run.
        pulse_start(0);
        txe[0] = 1'b1;
        cxe[0] = 1'b1;
        wait_for(0, 0, "e_drive");
        rst[0] = 1'b1;
        @(negedge clk);
        check("e_tx",       32'(tx_w[0]),   32'd0);
        check("e_cx",       32'(cx_w[0]),   32'd0);
        check("e_busy",     32'(busy[0]),   32'd0);
        check("e_tx_count", 32'(tx_cnt[0]), 32'd0);
        check("e_rxe",      32'(rxe[0]),    32'd0);
        txe[0] = 1'b0;
        cxe[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst[0] = 1'b0;
        @(negedge clk);
        pulse_start(0);
        run_vecs(0, 0, 2);
        wait_for(0, 4, "e_done");
        check_end(0, 16'd3, 16'd3, 1'b0, 1'b0);

        // Mode 1: alternating control, only control=1 tokens come back.
        fill_mode1();
        pulse_start(1);
        run_vecs(1, 0, 3);
        wait_for(1, 4, "f_done");
        check_end(1, 16'd4, 16'd2, 1'b0, 1'b0);
        check("f_last_data", 32'(rx_data[1]), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
